// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: 4-digit multiplexed seven-segment scan with frame-synchronous double buffering
// clk, rst_n (async, active-low), enable, value_in[15:0], load, dp_in[3:0], blank_lz in;
// an[3:0], seg[6:0] ({g..a}), dp (all active-low), digit_sel[1:0], frame_done out
module seven_seg_scan_controller #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  logic [PW-1:0] prescaler, prescaler_nx;
  logic [15:0]   display, display_nx, pending, pending_nx;
  logic [1:0]    ds_nx;
  logic [3:0]    nib;
  logic          pending_valid, pending_valid_nx, lit, lit_nx, tick, fs, blank, on;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'ha: hex7 = 7'b0001000;
      4'hb: hex7 = 7'b0000011;
      4'hc: hex7 = 7'b1000110;
      4'hd: hex7 = 7'b0100001;
      4'he: hex7 = 7'b0000110;
      4'hf: hex7 = 7'b0001110;
    endcase
  endfunction
  // lit keeps the display dark from reset until the first tick selects digit 0
  always_comb begin
    tick             = enable && (prescaler == PW'(REFRESH_DIV - 1));
    fs               = tick && (digit_sel == 2'd3);
    prescaler_nx     = !enable ? prescaler : tick ? '0 : prescaler + 1'b1;
    ds_nx            = tick ? digit_sel + 2'd1 : digit_sel;
    lit_nx           = lit | tick;
    pending_nx       = load ? value_in : pending;
    display_nx       = (load && (!enable || fs)) ? value_in : (fs && pending_valid) ? pending : display;
    pending_valid_nx = fs ? 1'b0 : load ? enable : pending_valid;
    nib              = ds_nx == 2'd0 ? display_nx[15:12] : ds_nx == 2'd1 ? display_nx[11:8] :
                       ds_nx == 2'd2 ? display_nx[7:4] : display_nx[3:0];
    blank            = blank_lz && (ds_nx == 2'd0 ? ~|display_nx[15:12] : ds_nx == 2'd1 ? ~|display_nx[15:8] :
                       ds_nx == 2'd2 ? ~|display_nx[15:4] : 1'b0);
    on               = enable && lit_nx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prescaler     <= '0;
      digit_sel     <= 2'd3;
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      lit           <= 1'b0;
      an            <= 4'hf;
      seg           <= 7'h7f;
      dp            <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      prescaler     <= prescaler_nx;
      digit_sel     <= ds_nx;
      display       <= display_nx;
      pending       <= pending_nx;
      pending_valid <= pending_valid_nx;
      lit           <= lit_nx;
      an            <= on ? ~(4'b1000 >> ds_nx) : 4'hf;
      seg           <= (on && !blank) ? hex7(nib) : 7'h7f;
      dp            <= on ? ~dp_in[~ds_nx] : 1'b1;
      frame_done    <= fs;
    end
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller: directed self-checking bench for the scan controller with REFRESH_DIV=4
module tb_seven_seg_scan_controller;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0, an;
  logic [6:0]  seg;
  logic        dp, frame_done;
  logic [1:0]  digit_sel;
  int          n_cmp = 0, n_err = 0;
  seven_seg_scan_controller #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in), .load(load),
    .dp_in(dp_in), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
    .digit_sel(digit_sel), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    step(2);
    chk("rst_an", an, 4'hf);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ds", digit_sel, 2'd3);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("dark_an", an, 4'hf);
    end
    step(1);
    chk("t1_an", an, 4'h7);
    chk("t1_fd", frame_done, 1'b1);
    chk("t1_seg", seg, 7'b1000000);
    chk("t1_ds", digit_sel, 2'd0);
    step(1);
    chk("t1_fd_off", frame_done, 1'b0);
    step(3);
    chk("d1_an", an, 4'hb);
    step(4);
    chk("d2_an", an, 4'hd);
    step(4);
    chk("d3_an", an, 4'he);
    step(4);
    chk("f2_fd", frame_done, 1'b1);
    chk("f2_an", an, 4'h7);
    step(2);
    value_in = 16'h12af;
    load = 1'b1;
    step(1);
    load = 1'b0;
    chk("old_d0", seg, 7'b1000000);
    step(1);
    chk("old_d1", seg, 7'b1000000);
    step(4);
    chk("old_d2", seg, 7'b1000000);
    step(4);
    chk("old_d3", seg, 7'b1000000);
    dp_in = 4'b0100;
    step(4);
    chk("new_d0", seg, 7'b1111001);
    chk("new_fd", frame_done, 1'b1);
    step(4);
    chk("new_d1", seg, 7'b0100100);
    chk("dp_d1", dp, 1'b0);
    step(4);
    chk("new_d2", seg, 7'b0001000);
    chk("dp_d2", dp, 1'b1);
    dp_in = 4'b0000;
    step(4);
    chk("new_d3", seg, 7'b0001110);
    value_in = 16'h0005;
    load = 1'b1;
    blank_lz = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk("lz5_d0", seg, 7'h7f);
    step(4);
    chk("lz5_d1", seg, 7'h7f);
    step(4);
    chk("lz5_d2", seg, 7'h7f);
    step(4);
    chk("lz5_d3", seg, 7'b0010010);
    chk("lz5_an", an, 4'he);
    value_in = 16'h0000;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk("lz0_d0", seg, 7'h7f);
    blank_lz = 1'b0;
    step(1);
    chk("lz_off_d0", seg, 7'b1000000);
    step(11);
    chk("lz0_d3", seg, 7'b1000000);
    chk("lz0_d3_an", an, 4'he);
    step(3);
    value_in = 16'h8888;
    load = 1'b1;
    step(1);
    load = 1'b0;
    chk("fsl_seg", seg, 7'b0000000);
    chk("fsl_fd", frame_done, 1'b1);
    chk("fsl_pv", dut.pending_valid, 1'b0);
    step(4);
    chk("fsl_d1", seg, 7'b0000000);
    chk("fsl_d1_an", an, 4'hb);
    step(1);
    enable = 1'b0;
    step(1);
    chk("dis_an", an, 4'hf);
    chk("dis_seg", seg, 7'h7f);
    chk("dis_dp", dp, 1'b1);
    chk("dis_fd", frame_done, 1'b0);
    value_in = 16'h3333;
    load = 1'b1;
    step(1);
    load = 1'b0;
    chk("dis_pv", dut.pending_valid, 1'b0);
    step(8);
    chk("dis_an_end", an, 4'hf);
    chk("dis_ds", digit_sel, 2'd1);
    enable = 1'b1;
    step(1);
    chk("re_an", an, 4'hb);
    chk("re_seg", seg, 7'b0110000);
    chk("re_ds", digit_sel, 2'd1);
    step(2);
    chk("re_next_an", an, 4'hd);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hf);
    chk("arst_seg", seg, 7'h7f);
    chk("arst_ds", digit_sel, 2'd3);
    chk("arst_fd", frame_done, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("rel_fd0", frame_done, 1'b0);
    chk("rel_an0", an, 4'hf);
    step(1);
    chk("rel_fd", frame_done, 1'b1);
    chk("rel_an", an, 4'h7);
    chk("rel_seg", seg, 7'b1000000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
